// File: rtl/fp_add_pipe.sv
// rtl/fp_add_pipe.sv - pipelined float add/sub (capture, align, add, normalise/round)
// Define FP_ADD_FLAGS_EN to add the flags[2:0] = {overflow, underflow, inexact} output.

module fp_add_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 op,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef FP_ADD_FLAGS_EN
    output logic [2:0]           flags,
`endif
    output logic [EXP_W+MAN_W:0] sum
);

    localparam int N   = 1 + EXP_W + MAN_W;
    localparam int SW  = MAN_W + 4;
    localparam int AW  = MAN_W + 5;
    localparam int SAT = MAN_W + 3;
    localparam int SHW = $clog2(SAT + 1);
    localparam int LZW = $clog2(SW + 1);
    localparam int EW  = ((EXP_W > LZW) ? EXP_W : LZW) + 2;
    localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {TAG_NUM, TAG_ZERO, TAG_INF, TAG_NAN} tag_t;

    logic          cap_valid_q;
    logic [N-1:0]  cap_a_q, cap_b_q;

    logic          s1_valid_q;
    tag_t          s1_tag_q;
    logic          s1_sign_q, s1_sub_q;
    logic [EXP_W-1:0] s1_exp_q;
    logic [SW-1:0] s1_x_q, s1_y_q;

    logic          s2_valid_q;
    tag_t          s2_tag_q;
    logic          s2_sign_q;
    logic [EXP_W-1:0] s2_exp_q;
    logic [AW-1:0] s2_sum_q;

    logic          out_valid_q;
    logic [N-1:0]  sum_q;

    logic en;
    assign en        = out_ready | ~out_valid_q;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;

    // ---------------- S1: classify, swap, align ----------------
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb, ma_f, mb_f;
    logic             a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, b_gt;
    assign {sa, ea, ma} = cap_a_q;
    assign {sb, eb, mb} = cap_b_q;
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_nan  = (&ea) & (|ma);
    assign b_nan  = (&eb) & (|mb);
    assign a_inf  = (&ea) & ~(|ma);
    assign b_inf  = (&eb) & ~(|mb);
    assign ma_f   = a_zero ? '0 : ma;
    assign mb_f   = b_zero ? '0 : mb;
    assign b_gt   = {eb, mb_f} > {ea, ma_f};

    logic             x_sign, y_sign;
    logic [EXP_W-1:0] x_exp, y_exp, diff;
    logic [SW-1:0]    x_sig, y_sig, y_shr, y_al;
    logic [SHW-1:0]   sh;
    logic             lost;
    tag_t             tag_d;
    logic             s1_sign_d;

    always_comb begin
        x_sign = b_gt ? sb : sa;
        y_sign = b_gt ? sa : sb;
        x_exp  = b_gt ? eb : ea;
        y_exp  = b_gt ? ea : eb;
        x_sig  = b_gt ? {~b_zero, mb_f, 3'b000} : {~a_zero, ma_f, 3'b000};
        y_sig  = b_gt ? {~a_zero, ma_f, 3'b000} : {~b_zero, mb_f, 3'b000};
        diff   = x_exp - y_exp;
        sh     = (int'(diff) > SAT) ? SHW'(SAT) : SHW'(diff);
        y_shr  = y_sig >> sh;
        // Everything pushed below the sticky position still counts as inexact.
        lost   = |(y_sig & ~({SW{1'b1}} << sh));
        y_al   = {y_shr[SW-1:1], y_shr[0] | lost};

        tag_d     = TAG_NUM;
        s1_sign_d = x_sign;
        if (a_nan || b_nan) begin
            tag_d = TAG_NAN;
        end else if (a_inf && b_inf) begin
            tag_d     = (sa != sb) ? TAG_NAN : TAG_INF;
            s1_sign_d = sa;
        end else if (a_inf) begin
            tag_d     = TAG_INF;
            s1_sign_d = sa;
        end else if (b_inf) begin
            tag_d     = TAG_INF;
            s1_sign_d = sb;
        end else if (a_zero && b_zero) begin
            tag_d     = TAG_ZERO;
            s1_sign_d = sa & sb;
        end
    end

    // ---------------- S2: effective add / subtract ----------------
    logic [AW-1:0] s2_sum_d;
    assign s2_sum_d = s1_sub_q ? ({1'b0, s1_x_q} - {1'b0, s1_y_q})
                               : ({1'b0, s1_x_q} + {1'b0, s1_y_q});

    // ---------------- S3: normalise, round, pack ----------------
    function automatic logic [LZW-1:0] lzc(input logic [SW-1:0] v);
        logic [LZW-1:0] c;
        c = LZW'(SW);
        for (int i = 0; i < SW; i++) begin
            if (v[i]) c = LZW'(SW - 1 - i);
        end
        return c;
    endfunction

    logic             carry, g, r, st, rnd_up, ovf, unf, res_zero;
    logic [LZW-1:0]   lz;
    logic [SW-1:0]    norm;
    logic [EW-1:0]    e_n, e_r;
    logic [MAN_W+1:0] man_r;
    logic [MAN_W-1:0] mant;
    logic [N-1:0]     sum_d;

    always_comb begin
        carry    = s2_sum_q[AW-1];
        lz       = lzc(s2_sum_q[SW-1:0]);
        res_zero = (s2_sum_q == '0);
        if (carry) begin
            norm = {s2_sum_q[AW-1:2], |s2_sum_q[1:0]};
            e_n  = EW'(s2_exp_q) + EW'(1);
        end else begin
            norm = s2_sum_q[SW-1:0] << lz;
            e_n  = EW'(s2_exp_q) - EW'(lz);
        end
        g      = norm[2];
        r      = norm[1];
        st     = norm[0];
        rnd_up = g & (norm[3] | r | st);
        man_r  = {1'b0, norm[SW-1:3]} + (MAN_W+2)'(rnd_up);
        if (man_r[MAN_W+1]) begin
            mant = man_r[MAN_W:1];
            e_r  = e_n + EW'(1);
        end else begin
            mant = man_r[MAN_W-1:0];
            e_r  = e_n;
        end
        // e_r is two's complement; the top bit marks a negative exponent.
        ovf = ~e_r[EW-1] & (e_r >= EMAX);
        unf = e_r[EW-1] | (e_r == '0);

        case (s2_tag_q)
            TAG_NAN:  sum_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            TAG_INF:  sum_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            TAG_ZERO: sum_d = {s2_sign_q, {(N-1){1'b0}}};
            default: begin
                if (res_zero)  sum_d = '0;
                else if (ovf)  sum_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                else if (unf)  sum_d = {s2_sign_q, {(N-1){1'b0}}};
                else           sum_d = {s2_sign_q, e_r[EXP_W-1:0], mant};
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_valid_q <= 1'b0;
            cap_a_q     <= '0;
            cap_b_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_tag_q    <= TAG_NUM;
            s1_sign_q   <= 1'b0;
            s1_sub_q    <= 1'b0;
            s1_exp_q    <= '0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_tag_q    <= TAG_NUM;
            s2_sign_q   <= 1'b0;
            s2_exp_q    <= '0;
            s2_sum_q    <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
        end else if (en) begin
            cap_valid_q <= in_valid;
            if (in_valid) begin
                cap_a_q <= a;
                cap_b_q <= {b[N-1] ^ op, b[N-2:0]};
            end
            s1_valid_q <= cap_valid_q;
            if (cap_valid_q) begin
                s1_tag_q  <= tag_d;
                s1_sign_q <= s1_sign_d;
                s1_sub_q  <= x_sign ^ y_sign;
                s1_exp_q  <= x_exp;
                s1_x_q    <= x_sig;
                s1_y_q    <= y_al;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_tag_q  <= s1_tag_q;
                s2_sign_q <= s1_sign_q;
                s2_exp_q  <= s1_exp_q;
                s2_sum_q  <= s2_sum_d;
            end
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) sum_q <= sum_d;
        end
    end

`ifdef FP_ADD_FLAGS_EN
    logic [2:0] flags_d, flags_q;
    always_comb begin
        flags_d = 3'b000;
        if (s2_tag_q == TAG_NUM && !res_zero) begin
            if (ovf)      flags_d = 3'b101;
            else if (unf) flags_d = 3'b011;
            else          flags_d = {2'b00, g | r | st};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  flags_q <= 3'b000;
        else if (en && s2_valid_q)   flags_q <= flags_d;
    end
    assign flags = flags_q;
`endif

endmodule

// File: tb/tb_fp_add_pipe.sv
// tb/tb_fp_add_pipe.sv - directed-vector bench for fp_add_pipe (single precision)

module tb_fp_add_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
`ifdef FP_ADD_FLAGS_EN
    logic [2:0]  flags;
`endif

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] va [0:7];
    logic [31:0] vb [0:7];
    logic        vop[0:7];
    logic [31:0] xs [0:7];
    logic [2:0]  xf [0:7];
    logic [31:0] rs [0:7];
    logic [2:0]  rf [0:7];
    logic        rv [0:7];

    fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef FP_ADD_FLAGS_EN
        .flags(flags),
`endif
        .sum(sum)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pushes n vectors back-to-back and records the n results, one per cycle.
    task automatic run_stream(input int n);
        for (int c = 0; c < n + 3; c++) begin
            if (c < n) begin
                in_valid = 1'b1; a = va[c]; b = vb[c]; op = vop[c];
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (c >= 3) begin
                rv[c-3] = out_valid;
                rs[c-3] = sum;
`ifdef FP_ADD_FLAGS_EN
                rf[c-3] = flags;
`else
                rf[c-3] = 3'b000;
`endif
            end
        end
    endtask

    task automatic test_reset();
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        n_vec++; if (sum !== 32'h0) begin n_bad++; $display("FAIL reset sum: got %h want 00000000", sum); end
        n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
`ifdef FP_ADD_FLAGS_EN
        n_vec++; if (flags !== 3'b000) begin n_bad++; $display("FAIL reset flags: got %b want 000", flags); end
`endif
    endtask

    task automatic test_latency();
        in_valid = 1'b1; a = 32'h3F800000; b = 32'h3F800000; op = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_vec++;
            if (out_valid !== (k == 3)) begin
                n_bad++; $display("FAIL latency edge+%0d out_valid: got %b want %b", k, out_valid, k == 3);
            end
            if (k == 3) begin
                n_vec++;
                if (sum !== 32'h40000000) begin n_bad++; $display("FAIL latency sum: got %h want 40000000", sum); end
            end
        end
    endtask

    task automatic check_stream(input string name, input int n);
        run_stream(n);
        for (int i = 0; i < n; i++) begin
            n_vec++;
            if (rv[i] !== 1'b1 || rs[i] !== xs[i]) begin
                n_bad++; $display("FAIL %s[%0d]: valid=%b sum=%h want valid=1 sum=%h", name, i, rv[i], rs[i], xs[i]);
            end
`ifdef FP_ADD_FLAGS_EN
            n_vec++;
            if (rf[i] !== xf[i]) begin
                n_bad++; $display("FAIL %s[%0d] flags: got %b want %b", name, i, rf[i], xf[i]);
            end
`endif
        end
    endtask

    task automatic test_arith();
        va  = '{32'h3F800000, 32'h3FC00000, 32'h40400000, 32'h3F800000, 32'hBF800000, 32'h3F800000, 0, 0};
        vb  = '{32'h3F800000, 32'h40200000, 32'h3F800000, 32'h40400000, 32'hBF800000, 32'h3F800000, 0, 0};
        vop = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        xs  = '{32'h40000000, 32'h40800000, 32'h40000000, 32'hC0000000, 32'hC0000000, 32'h00000000, 0, 0};
        xf  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        check_stream("arith", 6);
    endtask

    task automatic test_round_range();
        va  = '{32'h3F800000, 32'h3F800000, 32'h3F800001, 32'h3FFFFFFF, 32'h7F7FFFFF, 32'h00800001, 0, 0};
        vb  = '{32'h33800000, 32'h33C00000, 32'h33800000, 32'h33800000, 32'h7F7FFFFF, 32'h00800000, 0, 0};
        vop = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        xs  = '{32'h3F800000, 32'h3F800001, 32'h3F800002, 32'h40000000, 32'h7F800000, 32'h00000000, 0, 0};
        xf  = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b101, 3'b011, 3'b000, 3'b000};
        check_stream("round", 6);
    endtask

    task automatic test_special();
        va  = '{32'h7F800000, 32'h7F800000, 32'h3F800000, 32'h80000000, 32'h00000000, 32'h00000001, 32'h7FC00001, 32'h80000000};
        vb  = '{32'h7F800000, 32'h3F800000, 32'h7F800000, 32'h80000000, 32'h80000000, 32'h3F800000, 32'h3F800000, 32'h00000000};
        vop = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        xs  = '{32'h7FC00000, 32'h7F800000, 32'hFF800000, 32'h80000000, 32'h00000000, 32'h3F800000, 32'h7FC00000, 32'h80000000};
        xf  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        check_stream("special", 8);
    endtask

    task automatic push3_then_stall();
        va  = '{32'h3F800000, 32'h3FC00000, 32'hBF800000, 0, 0, 0, 0, 0};
        vb  = '{32'h3F800000, 32'h40200000, 32'hBF800000, 0, 0, 0, 0, 0};
        xs  = '{32'h40000000, 32'h40800000, 32'hC0000000, 0, 0, 0, 0, 0};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = va[i]; b = vb[i]; op = 1'b0;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        push3_then_stall();
        for (int k = 0; k < 5; k++) begin
            tick();
            n_vec++;
            if (out_valid !== 1'b1 || sum !== xs[0] || in_ready !== 1'b0) begin
                n_bad++; $display("FAIL stall[%0d]: valid=%b sum=%h in_ready=%b want 1 %h 0", k, out_valid, sum, in_ready, xs[0]);
            end
        end
        out_ready = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release in_ready: got %b want 1", in_ready); end
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_vec++;
            if (k < 3 && (out_valid !== 1'b1 || sum !== xs[k])) begin
                n_bad++; $display("FAIL drain[%0d]: valid=%b sum=%h want 1 %h", k, out_valid, sum, xs[k]);
            end else if (k == 3 && out_valid !== 1'b0) begin
                n_bad++; $display("FAIL drain end out_valid: got %b want 0", out_valid);
            end
        end
    endtask

    task automatic test_reset_midflight();
        push3_then_stall();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || sum !== 32'h0 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL midreset: valid=%b sum=%h in_ready=%b want 0 00000000 1", out_valid, sum, in_ready);
        end
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_vec++;
            if (out_valid !== 1'b0) begin n_bad++; $display("FAIL post-reset[%0d] out_valid: got %b want 0", k, out_valid); end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin rs[i] = '0; rf[i] = '0; rv[i] = 1'b0; end
        repeat (3) tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_latency();
        test_arith();
        test_round_range();
        test_special();
        test_back_to_back();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
